// File: rtl/dadda_err_monitor.sv
// Error-characterisation stage for an 8x8 approximate Dadda multiplier:
// recomputes the exact product and accumulates error statistics over a window of 2^LOG2_SAMPLES samples.
//
// state | meaning
// IDLE  | waiting for start, nothing accepted
// RUN   | accepting samples until N have been taken
// DRAIN | pipeline emptying into the accumulators
// DONE  | results valid and held until the next start
module dadda_err_monitor #(
    parameter int WIDTH        = 8,
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in1,
    input  logic [WIDTH-1:0]                in2,
    input  logic [2*WIDTH-1:0]              approx_prod,
    output logic                            busy,
    output logic                            result_valid,
    output logic [LOG2_SAMPLES:0]           err_count,
    output logic [2*WIDTH+LOG2_SAMPLES-1:0] sum_ed,
    output logic [2*WIDTH-1:0]              max_ed
);

    localparam int PW = 2 * WIDTH;
    localparam logic [LOG2_SAMPLES:0] LAST_IDX = {1'b0, {LOG2_SAMPLES{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [LOG2_SAMPLES:0] sample_cnt;
    logic                  s1_valid, s2_valid, s2_err;
    logic [PW-1:0]         s1_exact, s1_approx, s2_ed;
    logic [PW-1:0]         prod_c, ed_abs;
    logic [PW:0]           diff_pos, diff_neg;
    logic                  accept, open_win, last_sample;

    assign in_ready     = (state == RUN);
    assign busy         = (state == RUN) || (state == DRAIN);
    assign result_valid = (state == DONE);

    assign accept      = in_valid && in_ready;
    assign open_win    = start && ((state == IDLE) || (state == DONE));
    assign last_sample = accept && (sample_cnt == LAST_IDX);

    assign prod_c = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

    // One extra bit so the sign of approx - exact is visible; the magnitude always fits in PW bits.
    assign diff_pos = {1'b0, s1_approx} - {1'b0, s1_exact};
    assign diff_neg = {1'b0, s1_exact} - {1'b0, s1_approx};
    assign ed_abs   = diff_pos[PW] ? diff_neg[PW-1:0] : diff_pos[PW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_sample) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            s1_valid   <= 1'b0;
            s1_exact   <= '0;
            s1_approx  <= '0;
            s2_valid   <= 1'b0;
            s2_ed      <= '0;
            s2_err     <= 1'b0;
        end else if (open_win) begin
            sample_cnt <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + 1'b1;
                s1_exact   <= prod_c;
                s1_approx  <= approx_prod;
            end
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed  <= ed_abs;
                s2_err <= |ed_abs;
            end
        end
    end

    // Widths are sized so a full window of worst-case errors cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (open_win) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (s2_valid) begin
            err_count <= err_count + {{LOG2_SAMPLES{1'b0}}, s2_err};
            sum_ed    <= sum_ed + {{LOG2_SAMPLES{1'b0}}, s2_ed};
            if (s2_ed > max_ed) max_ed <= s2_ed;
        end
    end

endmodule

// File: tb/tb_dadda_err_monitor.sv
// Directed bench for dadda_err_monitor: a 4-sample instance for most scenarios
// and a 256-sample instance for the worst-case accumulator width.
module tb_dadda_err_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // N = 4 instance
    logic        s_start = 0, s_in_valid = 0, s_in_ready, s_busy, s_result_valid;
    logic [7:0]  s_in1 = 0, s_in2 = 0;
    logic [15:0] s_approx = 0;
    logic [2:0]  s_err_count;
    logic [17:0] s_sum_ed;
    logic [15:0] s_max_ed;

    // N = 256 instance
    logic        b_start = 0, b_in_valid = 0, b_in_ready, b_busy, b_result_valid;
    logic [7:0]  b_in1 = 0, b_in2 = 0;
    logic [15:0] b_approx = 0;
    logic [8:0]  b_err_count;
    logic [23:0] b_sum_ed;
    logic [15:0] b_max_ed;

    dadda_err_monitor #(.WIDTH(8), .LOG2_SAMPLES(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in1(s_in1), .in2(s_in2), .approx_prod(s_approx), .busy(s_busy),
        .result_valid(s_result_valid), .err_count(s_err_count), .sum_ed(s_sum_ed), .max_ed(s_max_ed)
    );

    dadda_err_monitor #(.WIDTH(8), .LOG2_SAMPLES(8)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in1(b_in1), .in2(b_in2), .approx_prod(b_approx), .busy(b_busy),
        .result_valid(b_result_valid), .err_count(b_err_count), .sum_ed(b_sum_ed), .max_ed(b_max_ed)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_s_start();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic wait_s_done(input string tag);
        int n = 0;
        while (!s_result_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(s_result_valid), 64'd1);
    endtask

    logic [7:0]  ma [4] = '{8'd10, 8'd200, 8'd255, 8'd1};
    logic [7:0]  mb [4] = '{8'd10, 8'd3,   8'd255, 8'd1};
    logic [15:0] mp [4] = '{16'd96, 16'd600, 16'd65535, 16'd0};
    logic [7:0]  xa [4] = '{8'd3, 8'd255, 8'd0, 8'd16};
    logic [7:0]  xb [4] = '{8'd5, 8'd255, 8'd7, 8'd16};
    logic [15:0] xp [4] = '{16'd15, 16'd65025, 16'd0, 16'd256};

    initial begin
        int          acc, guard, exp_err;
        logic [15:0] ex, ed, exp_max;
        logic [17:0] exp_sum;
        logic        v;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(s_in_ready), 0);
        chk("idle_busy", 64'(s_busy), 0);
        chk("idle_result_valid", 64'(s_result_valid), 0);

        // reset mid-RUN with samples in flight
        pulse_s_start();
        s_in1 = 8'd9; s_in2 = 8'd9; s_approx = 16'd0; s_in_valid = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(s_in_ready), 0);
        chk("rst_busy", 64'(s_busy), 0);
        chk("rst_result_valid", 64'(s_result_valid), 0);
        chk("rst_err_count", 64'(s_err_count), 0);
        chk("rst_sum_ed", 64'(s_sum_ed), 0);
        chk("rst_max_ed", 64'(s_max_ed), 0);
        s_in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_in_ready", 64'(s_in_ready), 0);
        chk("post_rst_sum_ed", 64'(s_sum_ed), 0);

        // exact window; sample offered alongside start must not be taken
        s_start = 1'b1; s_in_valid = 1'b1;
        s_in1 = 8'd1; s_in2 = 8'd1; s_approx = 16'd100;
        tick();
        s_start = 1'b0; s_in_valid = 1'b0;
        chk("run_in_ready", 64'(s_in_ready), 1);
        chk("run_busy", 64'(s_busy), 1);
        for (int i = 0; i < 4; i++) begin
            s_in1 = xa[i]; s_in2 = xb[i]; s_approx = xp[i]; s_in_valid = 1'b1;
            tick();
        end
        s_in_valid = 1'b0;
        chk("drain_in_ready", 64'(s_in_ready), 0);
        chk("drain_busy", 64'(s_busy), 1);
        tick(); tick();
        chk("exact_rv_k2", 64'(s_result_valid), 0);
        tick();
        chk("exact_rv_k3", 64'(s_result_valid), 1);
        chk("exact_busy", 64'(s_busy), 0);
        chk("exact_err_count", 64'(s_err_count), 0);
        chk("exact_sum_ed", 64'(s_sum_ed), 0);
        chk("exact_max_ed", 64'(s_max_ed), 0);

        // mixed errors with bubbles; start pulses in RUN and DRAIN are ignored
        pulse_s_start();
        chk("restart_rv_fall", 64'(s_result_valid), 0);
        chk("restart_busy", 64'(s_busy), 1);
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b0; s_start = 1'b1;
            tick();
            s_start = 1'b0;
            s_in1 = ma[i]; s_in2 = mb[i]; s_approx = mp[i]; s_in_valid = 1'b1;
            tick();
        end
        s_in_valid = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("mixed_drain_busy", 64'(s_busy), 1);
        wait_s_done("mixed_done");
        chk("mixed_err_count", 64'(s_err_count), 3);
        chk("mixed_sum_ed", 64'(s_sum_ed), 515);
        chk("mixed_max_ed", 64'(s_max_ed), 510);
        tick(); tick();
        chk("mixed_hold_sum", 64'(s_sum_ed), 515);

        // random bubbles and start pulses against a reference model, second window after DONE
        pulse_s_start();
        chk("rand_rv_fall", 64'(s_result_valid), 0);
        chk("rand_cleared", 64'(s_sum_ed), 0);
        acc = 0; guard = 0; exp_err = 0; exp_sum = '0; exp_max = '0;
        while (acc < 4 && guard < 200) begin
            v = 1'($urandom_range(0, 1));
            s_in1 = 8'($urandom_range(0, 255));
            s_in2 = 8'($urandom_range(0, 255));
            ex = 16'(s_in1) * 16'(s_in2);
            s_approx = ($urandom_range(0, 2) == 0) ? ex : 16'($urandom_range(0, 65535));
            s_in_valid = v;
            s_start = ($urandom_range(0, 3) == 0);
            if (s_in_ready && v) begin
                ed = (s_approx > ex) ? s_approx - ex : ex - s_approx;
                if (ed != 0) exp_err++;
                exp_sum = exp_sum + 18'(ed);
                if (ed > exp_max) exp_max = ed;
                acc++;
            end
            tick();
            guard++;
        end
        chk("rand_accepted", 64'(acc), 4);
        chk("rand_ready_drop", 64'(s_in_ready), 0);
        s_in_valid = 1'b1; s_start = 1'b1;
        s_in1 = 8'd255; s_in2 = 8'd255; s_approx = 16'd0;
        tick(); tick();
        s_in_valid = 1'b0; s_start = 1'b0;
        wait_s_done("rand_done");
        chk("rand_err_count", 64'(s_err_count), 64'(exp_err));
        chk("rand_sum_ed", 64'(s_sum_ed), 64'(exp_sum));
        chk("rand_max_ed", 64'(s_max_ed), 64'(exp_max));

        // worst case on the 256-sample instance
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_in1 = 8'd255; b_in2 = 8'd255; b_approx = 16'd0; b_in_valid = 1'b1;
        repeat (256) tick();
        b_in_valid = 1'b0;
        chk("big_ready_drop", 64'(b_in_ready), 0);
        guard = 0;
        while (!b_result_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk("big_done", 64'(b_result_valid), 1);
        chk("big_err_count", 64'(b_err_count), 256);
        chk("big_sum_ed", 64'(b_sum_ed), 64'd16646400);
        chk("big_max_ed", 64'(b_max_ed), 65025);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
